regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the processor datapath, succeeding the fixed 32x32 two-read-port file. It adds a configurable number of read ports and an optional hardwired-zero register 0. It also adds same-cycle write-to-read bypass, a per-register pending-write scoreboard for pipeline hazard checks, and a sequenced clear engine that zeroes the array one entry per cycle.

---
 rtl/rf_pkg.sv | 6 +
 rtl/rf_read_port.sv | 36 +++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types: clear-engine states and default datapath widths.
package rf_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
endpackage

// File: rtl/rf_read_port.sv
// One read port: array mux with zero-register masking, write bypass and pending lookup.
// Latency 0 (pure combinational); no backpressure.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DATA_W-1:0]    regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] pend,
  input  logic [ADDR_W-1:0]    sel,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_pend
);
  logic zero_hit;
  logic byp_hit;

  assign zero_hit = (ZERO_REG != 0) && (sel == '0);
  // wr_en arrives already gated by the clear engine, so bypass is off while clearing
  assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == sel) && !zero_hit;

  always_comb begin
    rd_data = regs[sel];
    rd_pend = pend[sel];
    if (zero_hit) begin
      rd_data = '0;
      rd_pend = 1'b0;
    end else if (byp_hit) begin
      rd_data = wr_data;
      rd_pend = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending-write scoreboard and sequenced clear engine.
// Reads latency 0; writes/reserves take effect at the edge; while busy, writes/reserves/clr_req are dropped.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        write_address,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [N_RD*ADDR_W-1:0]   read_sel,
  output logic [N_RD*DATA_W-1:0]   read_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [N_RD-1:0]          read_pend,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              wr_en, wr_ok, rsv_ok;

  assign busy   = (state == RF_CLEAR);
  assign wr_en  = RegWrite && !busy;
  assign wr_ok  = wr_en && !((ZERO_REG != 0) && (write_address == '0));
  assign rsv_ok = rsv_en && !busy && !((ZERO_REG != 0) && (rsv_addr == '0));

  always_comb begin
    state_nxt = state;
    case (state)
      RF_IDLE:  if (clr_req) state_nxt = RF_CLEAR;
      RF_CLEAR: if (cnt == {ADDR_W{1'b1}}) state_nxt = RF_IDLE;
      default:  state_nxt = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == RF_IDLE) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else if (busy) begin
      regs[cnt] <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[write_address] <= write_data;
        pend[write_address] <= 1'b0;
      end
      // a reserve in the same cycle is a newer producer, so it overrides the write's clear
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_port (
      .regs    (regs),
      .pend    (pend),
      .sel     (read_sel[k*ADDR_W +: ADDR_W]),
      .wr_en   (wr_en),
      .wr_addr (write_address),
      .wr_data (write_data),
      .rd_data (read_data[k*DATA_W +: DATA_W]),
      .rd_pend (read_pend[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; expectations queued by stimulus, compared by a negedge monitor.
// Latency: checks sampled at negedge after each stimulus edge.
// Backpressure: none; bounded waits flag an expired wait as a failure.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [9:0]  read_sel;
    logic [63:0] read_data, read_data_nb;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [1:0]  read_pend, read_pend_nb;
    logic        clr_req;
    logic        busy, busy_nb;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .read_sel(read_sel), .read_data(read_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .read_pend(read_pend),
        .clr_req(clr_req), .busy(busy)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .read_sel(read_sel), .read_data(read_data_nb),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .read_pend(read_pend_nb),
        .clr_req(clr_req), .busy(busy_nb)
    );

    // kind: 0 read_data, 1 read_pend, 2 busy, 3 read_data of no-bypass instance
    typedef struct packed {
        logic [1:0]  kind;
        logic        port;
        logic [31:0] val;
        logic [95:0] name;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic put(input logic [1:0] kind, input logic port, input logic [31:0] val,
                       input logic [95:0] name);
        exp_t e;
        e.kind = kind; e.port = port; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel2(input logic [4:0] p1, input logic [4:0] p0);
        read_sel = {p1, p0};
    endtask

    task automatic wait_idle(input int max_cycles);
        int waited;
        waited = 0;
        while (busy && waited < max_cycles) begin
            step();
            waited++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy still high after %0d cycles", max_cycles);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) #2;
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = q.pop_front();
            case (e.kind)
                2'd0:    got = read_data[e.port*32 +: 32];
                2'd1:    got = {31'd0, read_pend[e.port]};
                2'd2:    got = {31'd0, busy};
                default: got = read_data_nb[e.port*32 +: 32];
            endcase
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %0s port%0d: got %h want %h", e.name, e.port, got, e.val);
            end
        end
    end

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; write_address = '0; write_data = '0;
        read_sel = '0; rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
        sel2(5'd4, 5'd3);
        #2;
        total++;
        if (busy !== 1'b0 || read_pend !== 2'b00 || read_data !== 64'd0) begin
            bad++;
            $display("FAIL rst_direct: busy=%b pend=%b data=%h", busy, read_pend, read_data);
        end
        put(2, 0, 0, "rst_busy"); put(1, 0, 0, "rst_pend"); put(1, 1, 0, "rst_pend");
        put(0, 0, 0, "rst_rd");   put(0, 1, 0, "rst_rd");
        step();
        rst_n = 1'b1;

        // basic writes then two-port read
        step(); RegWrite = 1; write_address = 3; write_data = 32'hFFFF0000;
        step(); write_address = 4; write_data = 32'h0000FFFF;
        step(); RegWrite = 0;
        put(0, 0, 32'hFFFF0000, "rd_r3"); put(0, 1, 32'h0000FFFF, "rd_r4");

        // bypass vs no-bypass instance
        step(); RegWrite = 1; write_address = 3; write_data = 32'h0F0F0F0F; sel2(5'd4, 5'd3);
        put(0, 0, 32'h0F0F0F0F, "byp_same"); put(3, 0, 32'hFFFF0000, "nobyp_old");
        put(1, 0, 0, "byp_pend");
        step(); RegWrite = 0;
        put(0, 0, 32'h0F0F0F0F, "byp_next"); put(3, 0, 32'h0F0F0F0F, "nobyp_next");

        // register 0 hardwired
        step(); RegWrite = 1; write_address = 0; write_data = 32'hDEADBEEF;
        rsv_en = 1; rsv_addr = 0; sel2(5'd0, 5'd0);
        put(0, 0, 0, "r0_byp"); put(0, 1, 0, "r0_byp"); put(3, 0, 0, "r0_nobyp");
        step(); RegWrite = 0; rsv_en = 0;
        put(0, 0, 0, "r0_rd"); put(1, 0, 0, "r0_pend"); put(1, 1, 0, "r0_pend");

        // reservation scoreboard
        step(); rsv_en = 1; rsv_addr = 5; sel2(5'd5, 5'd5);
        put(1, 0, 0, "rsv_early");
        step(); rsv_en = 0;
        put(1, 0, 1, "rsv_set"); put(1, 1, 1, "rsv_set");
        step(); RegWrite = 1; write_address = 5; write_data = 32'h12345678;
        put(1, 0, 0, "rsv_bypkill"); put(0, 0, 32'h12345678, "r5_byp");
        step(); RegWrite = 0;
        put(1, 0, 0, "rsv_clr"); put(0, 1, 32'h12345678, "r5_rd");
        step(); RegWrite = 1; write_address = 6; write_data = 32'hAAAA5555;
        rsv_en = 1; rsv_addr = 6; sel2(5'd6, 5'd6);
        put(0, 0, 32'hAAAA5555, "r6_byp"); put(1, 0, 0, "r6_byp_pend");
        step(); RegWrite = 0; rsv_en = 0;
        put(1, 0, 1, "wr_rsv_pend"); put(0, 1, 32'hAAAA5555, "r6_rd");

        // fill then sequenced clear
        for (int i = 1; i < 32; i++) begin
            step(); RegWrite = 1; write_address = 5'(i); write_data = i;
        end
        step(); RegWrite = 0; sel2(5'd31, 5'd1);
        put(0, 0, 1, "fill_r1"); put(0, 1, 31, "fill_r31"); put(1, 0, 0, "fill_pend");
        step(); clr_req = 1;
        put(2, 0, 0, "clr_pre");
        step(); clr_req = 0;
        put(2, 0, 1, "clr_c0");
        for (int c = 1; c < 32; c++) begin
            step();
            RegWrite = (c == 5); write_address = 2; write_data = 32'h0000DEAD;
            rsv_en = (c == 5); rsv_addr = 7;
            if (c == 5) begin
                sel2(5'd20, 5'd2);
                put(0, 0, 0, "clr_wr_drop"); put(0, 1, 20, "clr_live_rd");
            end
            if (c == 6) begin
                sel2(5'd7, 5'd2);
                put(0, 0, 0, "clr_r2_after"); put(1, 1, 0, "clr_rsv_drop");
            end
            if (c == 31) put(2, 0, 1, "clr_c31");
        end
        step(); RegWrite = 1; write_address = 9; write_data = 32'h99; sel2(5'd9, 5'd0);
        put(2, 0, 0, "clr_done"); put(0, 1, 32'h99, "post_byp");
        step(); RegWrite = 0;
        for (int i = 0; i < 32; i++) begin
            sel2(5'(i), 5'(i));
            put(0, 0, (i == 9) ? 32'h99 : 32'h0, "post_rd");
            put(1, 1, 0, "post_pend");
            step();
        end

        // reset mid-clear
        RegWrite = 1; write_address = 20; write_data = 20;
        step(); write_address = 25; write_data = 25;
        step(); RegWrite = 0; clr_req = 1;
        step(); clr_req = 0; sel2(5'd25, 5'd20);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 9) begin
                put(2, 0, 1, "mid_busy"); put(0, 0, 20, "mid_r20"); put(0, 1, 25, "mid_r25");
            end
        end
        rst_n = 1'b0;
        put(2, 0, 0, "arst_busy"); put(0, 0, 0, "arst_r20"); put(0, 1, 0, "arst_r25");
        step();
        rst_n = 1'b1;

        // restart from cnt 0: r1 survives cycle 1, gone by cycle 2
        step(); RegWrite = 1; write_address = 1; write_data = 32'h11;
        step(); RegWrite = 0; clr_req = 1; sel2(5'd1, 5'd1);
        step(); clr_req = 0;
        put(2, 0, 1, "rst_c0");
        step(); put(0, 0, 32'h11, "rst_c1_r1");
        step(); put(0, 0, 0, "rst_c2_r1");
        for (int c = 3; c < 32; c++) step();
        put(2, 0, 1, "rst_c31");
        step(); put(2, 0, 0, "rst_done");
        step();
        wait_idle(4);
        step();
        if (bad != 0) $display("FAIL summary: %0d of %0d checks failed", bad, total);
        else          $display("PASS: all %0d checks passed", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
